// File: rtl/branch_pkg.sv
// Shared types and constants for the branch condition unit.
//   cond_e  : 3-bit branch condition codes
//   state_e : output-stage occupancy (EMPTY / FULL)
//   FLAG_*  : bit positions of z/v/n inside the {z,v,n} flag vector
//   PC_INC  : fall-through increment for a not-taken branch
package branch_pkg;

  typedef enum logic [2:0] {
    COND_NE = 3'b000,
    COND_EQ = 3'b001,
    COND_GT = 3'b010,
    COND_LT = 3'b011,
    COND_GE = 3'b100,
    COND_LE = 3'b101,
    COND_OV = 3'b110,
    COND_AL = 3'b111
  } cond_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 0;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational condition evaluator.
//   cond  : condition code (branch_pkg::cond_e encoding)
//   z,v,n : effective zero / overflow / negative flags
//   taken : 1 when the condition holds
module cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] cond,
  input  logic       z,
  input  logic       v,
  input  logic       n,
  output logic       taken
);

  // Decode the condition code against the supplied flags.
  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_NE: taken = ~z;
      COND_EQ: taken = z;
      COND_GT: taken = ~z & (n == v);
      COND_LT: taken = (n != v);
      COND_GE: taken = z | (n == v);
      COND_LE: taken = z | (n != v);
      COND_OV: taken = v;
      COND_AL: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Branch condition unit: keeps the architectural {z,v,n} flag register,
// resolves one branch per cycle and presents the result through a
// single-entry valid/ready output stage.
//   clk, rst                : clock, asynchronous active-high reset
//   flag_we, alu_z/v/n      : flag register write strobe and ALU flags
//   br_valid/br_ready       : branch request handshake
//   br_cond/br_pc/br_offset : condition code, branch address, signed offset
//   res_valid/res_ready     : resolution handshake
//   res_taken/res_target    : resolved direction and next PC
//   flags                   : flag register {z,v,n}
//   taken_cnt               : saturating count of taken branches
module branch_cond_unit
  import branch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flag_we,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_n,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_cond,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_offset,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_taken,
  output logic [31:0] res_target,
  output logic [2:0]  flags,
  output logic        [15:0] taken_cnt
);

  state_e      state_q, state_d;
  logic [2:0]  flags_q, flags_d;
  logic        res_taken_q, res_taken_d;
  logic [31:0] res_target_q, res_target_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;

  logic [2:0]  alu_flags;
  logic [2:0]  eff_flags;
  logic        accept;
  logic        cond_taken;

  assign alu_flags = {alu_z, alu_v, alu_n};

  // A same-cycle flag write is forwarded so the branch sees the new flags.
  assign eff_flags = flag_we ? alu_flags : flags_q;

  // Ready while the stage is empty or is being drained this cycle; held low
  // during reset so nothing is accepted then.
  assign br_ready = ~rst & ((state_q == EMPTY) | res_ready);
  assign accept   = br_valid & br_ready;

  cond_eval u_cond_eval (
    .cond  (br_cond),
    .z     (eff_flags[FLAG_Z]),
    .v     (eff_flags[FLAG_V]),
    .n     (eff_flags[FLAG_N]),
    .taken (cond_taken)
  );

  // Next-state computation for the output stage, flags and taken counter.
  always_comb begin
    state_d      = state_q;
    flags_d      = flags_q;
    res_taken_d  = res_taken_q;
    res_target_d = res_target_q;
    taken_cnt_d  = taken_cnt_q;

    if (flag_we) begin
      flags_d = alu_flags;
    end else begin
      flags_d = flags_q;
    end

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = FULL;
        end else begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (accept) begin
          state_d = FULL;
        end else if (res_ready) begin
          state_d = EMPTY;
        end else begin
          state_d = FULL;
        end
      end
      default: state_d = EMPTY;
    endcase

    // The result only changes on accept, so a held result is immune to
    // later flag writes.
    if (accept) begin
      res_taken_d = cond_taken;
      if (cond_taken) begin
        res_target_d = br_pc + br_offset;
      end else begin
        res_target_d = br_pc + PC_INC;
      end
    end else begin
      res_taken_d  = res_taken_q;
      res_target_d = res_target_q;
    end

    if (accept && cond_taken && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end else begin
      taken_cnt_d = taken_cnt_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      flags_q      <= 3'b000;
      res_taken_q  <= 1'b0;
      res_target_q <= 32'd0;
      taken_cnt_q  <= 16'd0;
    end else begin
      state_q      <= state_d;
      flags_q      <= flags_d;
      res_taken_q  <= res_taken_d;
      res_target_q <= res_target_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign res_valid  = (state_q == FULL);
  assign res_taken  = res_taken_q;
  assign res_target = res_target_q;
  assign flags      = flags_q;
  assign taken_cnt  = taken_cnt_q;

endmodule
